// File: rtl/div_ratio_decoder.sv
// div_ratio_decoder: recovers the average divide ratio of a fractional-N loop.
// Sums mpr_i over a window of 1024 << win_sel clko cycles after an optional
// settle phase. It then reports the average as a 6-bit integer part and a
// 10-bit fractional word.
// Optional feature: define DIV_RATIO_DECODER_ERRCHK_EN to compile in the
// comparison against {exp_n_i, exp_frac_i}. When enabled, err_o is a sticky flag.
module div_ratio_decoder #(
  parameter int SETTLE_CYC = 8,
  parameter int SUM_W      = 19
) (
  input  logic       clko,
  input  logic       rstn_s,
  input  logic [5:0] mpr_i,
  input  logic       start_i,
  input  logic       cont_i,
  input  logic [1:0] win_sel_i,
  input  logic [5:0] exp_n_i,
  input  logic [9:0] exp_frac_i,
  input  logic [3:0] tol_i,
  output logic       busy_o,
  output logic       valid_o,
  output logic [5:0] n_est_o,
  output logic [9:0] frac_est_o,
  output logic       err_o
);

  localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ACCUM  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [SC_W-1:0]  set_cnt_q, set_cnt_d;
  logic [13:0]      win_cnt_q, win_cnt_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [1:0]       win_sel_q, win_sel_d;
  logic [5:0]       n_est_q, n_est_d;
  logic [9:0]       frac_q, frac_d;
  logic             valid_q, valid_d;
  logic             err_clr;
  logic             err_chk;
  logic [13:0]      win_last;
  logic [15:0]      q;

  // Averaging divides by the window length. The integer-ratio scale of 1024 is
  // already in the fixed-point format, so only the extra win_sel doubling is
  // shifted out. Low bits are dropped with no rounding.
  function automatic logic [15:0] trunc_shift(input logic [SUM_W-1:0] s,
                                              input logic [1:0]       sh);
    return 16'(s >> sh);
  endfunction

  assign win_last = (14'd1024 << win_sel_q) - 14'd1;
  assign q        = trunc_shift(sum_q, win_sel_q);

  // State register
  always_ff @(posedge clko or negedge rstn_s) begin
    if (!rstn_s) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next state and datapath next values
  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    win_cnt_d = win_cnt_q;
    sum_d     = sum_q;
    win_sel_d = win_sel_q;
    n_est_d   = n_est_q;
    frac_d    = frac_q;
    valid_d   = 1'b0;
    err_clr   = 1'b0;
    err_chk   = 1'b0;
    case (state_q)
      S_IDLE: begin
        sum_d     = '0;
        win_cnt_d = '0;
        set_cnt_d = '0;
        if (start_i) begin
          win_sel_d = win_sel_i;
          err_clr   = 1'b1;
          state_d   = (SETTLE_CYC == 0) ? S_ACCUM : S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (int'(set_cnt_q) == SETTLE_CYC - 1) begin
          set_cnt_d = '0;
          state_d   = S_ACCUM;
        end else begin
          set_cnt_d = set_cnt_q + SC_W'(1);
        end
      end
      S_ACCUM: begin
        sum_d     = sum_q + SUM_W'(mpr_i);
        win_cnt_d = win_cnt_q + 14'd1;
        if (win_cnt_q == win_last) state_d = S_DONE;
      end
      S_DONE: begin
        n_est_d   = q[15:10];
        frac_d    = q[9:0];
        valid_d   = 1'b1;
        err_chk   = 1'b1;
        sum_d     = '0;
        win_cnt_d = '0;
        state_d   = cont_i ? S_ACCUM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counters, accumulator, latched window and result registers
  always_ff @(posedge clko or negedge rstn_s) begin
    if (!rstn_s) begin
      set_cnt_q <= '0;
      win_cnt_q <= '0;
      sum_q     <= '0;
      win_sel_q <= '0;
      n_est_q   <= '0;
      frac_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      set_cnt_q <= set_cnt_d;
      win_cnt_q <= win_cnt_d;
      sum_q     <= sum_d;
      win_sel_q <= win_sel_d;
      n_est_q   <= n_est_d;
      frac_q    <= frac_d;
      valid_q   <= valid_d;
    end
  end

  assign busy_o     = (state_q == S_SETTLE) || (state_q == S_ACCUM);
  assign valid_o    = valid_q;
  assign n_est_o    = n_est_q;
  assign frac_est_o = frac_q;

`ifdef DIV_RATIO_DECODER_ERRCHK_EN
  logic err_q, err_d;

  // True when the estimate is farther than tol from the expected word
  function automatic logic err_exceeds(input logic [15:0] est,
                                       input logic [15:0] expv,
                                       input logic [3:0]  tol);
    logic signed [16:0] diff;
    logic signed [16:0] mag;
    diff = $signed({1'b0, est}) - $signed({1'b0, expv});
    mag  = (diff < 0) ? -diff : diff;
    return mag > $signed({13'd0, tol});
  endfunction

  // Sticky error: cleared by an accepted start, set on an out-of-tolerance result
  always_comb begin
    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    else if (err_chk && err_exceeds(q, {exp_n_i, exp_frac_i}, tol_i)) err_d = 1'b1;
  end

  // Sticky error register
  always_ff @(posedge clko or negedge rstn_s) begin
    if (!rstn_s) err_q <= 1'b0;
    else         err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_errchk;
  assign unused_errchk = ^{exp_n_i, exp_frac_i, tol_i, err_clr, err_chk};
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_div_ratio_decoder.sv
// Directed bench for div_ratio_decoder (default parameters).
module tb_div_ratio_decoder;
  logic       clko = 1'b0;
  logic       rstn_s = 1'b1;
  logic [5:0] mpr_i = 6'd20;
  logic       start_i = 1'b0;
  logic       cont_i = 1'b0;
  logic [1:0] win_sel_i = 2'd0;
  logic [5:0] exp_n_i = 6'd20;
  logic [9:0] exp_frac_i = 10'd0;
  logic [3:0] tol_i = 4'd2;
  logic       busy_o;
  logic       valid_o;
  logic [5:0] n_est_o;
  logic [9:0] frac_est_o;
  logic       err_o;

  int nvec = 0;
  int nerr = 0;
  int pc = 0;
  int mode = 0;
  logic [5:0] cval = 6'd20;
  int cyc;
  int pulses;
  logic exp_err;

  div_ratio_decoder dut (
    .clko       (clko),
    .rstn_s     (rstn_s),
    .mpr_i      (mpr_i),
    .start_i    (start_i),
    .cont_i     (cont_i),
    .win_sel_i  (win_sel_i),
    .exp_n_i    (exp_n_i),
    .exp_frac_i (exp_frac_i),
    .tol_i      (tol_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .n_est_o    (n_est_o),
    .frac_est_o (frac_est_o),
    .err_o      (err_o)
  );

  always #5 clko = ~clko;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [5:0] pat(input int m, input int p, input logic [5:0] c);
    case (m)
      1:       return (p % 2 == 1) ? 6'd21 : 6'd20;
      2:       return (p % 256 == 0) ? 6'd21 : 6'd20;
      default: return c;
    endcase
  endfunction

  task automatic step();
    @(negedge clko);
    pc++;
    mpr_i = pat(mode, pc, cval);
  endtask

  task automatic kick();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic wait_valid(input int limit, input int inject_at, output int n);
    n = 0;
    while (valid_o !== 1'b1 && n < limit) begin
      start_i = (n == inject_at) ? 1'b1 : 1'b0;
      step();
      n++;
    end
    start_i = 1'b0;
  endtask

  task automatic quiet(input int len, output int np);
    np = 0;
    for (int i = 0; i < len; i++) begin
      step();
      if (valid_o === 1'b1) np++;
    end
  endtask

  initial begin
`ifdef DIV_RATIO_DECODER_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    #1 rstn_s = 1'b0;
    step(); step(); step();
    chk("rst_busy", busy_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_n", n_est_o, 0);
    chk("rst_frac", frac_est_o, 0);
    chk("rst_err", err_o, 0);
    rstn_s = 1'b1;
    step();

    // Constant ratio 20, shortest window
    mode = 0; cval = 6'd20; win_sel_i = 2'd0;
    kick();
    wait_valid(1200, -1, cyc);
    chk("a_latency", cyc, 1033);
    chk("a_n", n_est_o, 20);
    chk("a_frac", frac_est_o, 0);
    chk("a_busy", busy_o, 0);
    step();
    chk("a_pulse_width", valid_o, 0);
    quiet(50, pulses);
    chk("a_hold_n", n_est_o, 20);
    chk("a_no_extra", pulses, 0);

    // Alternating 20/21, window 2048; win_sel changed after start must not matter
    mode = 1; win_sel_i = 2'd1;
    kick();
    win_sel_i = 2'd0;
    wait_valid(2300, -1, cyc);
    chk("b_latency", cyc, 2057);
    chk("b_n", n_est_o, 20);
    chk("b_frac", frac_est_o, 512);
    chk("b_busy", busy_o, 0);

    // Continuous mode, ratio 33
    mode = 0; cval = 6'd33; cont_i = 1'b1;
    kick();
    wait_valid(1200, -1, cyc);
    chk("c_first", cyc, 1033);
    chk("c_n1", n_est_o, 33);
    step();
    wait_valid(1200, -1, cyc);
    chk("c_period2", cyc + 1, 1025);
    chk("c_n2", n_est_o, 33);
    chk("c_busy_rearm", busy_o, 1);
    cont_i = 1'b0;
    step();
    wait_valid(1200, -1, cyc);
    chk("c_period3", cyc + 1, 1025);
    chk("c_n3", n_est_o, 33);
    step();
    chk("c_busy_end", busy_o, 0);

    // Four 21s per 1024 cycles around 20 -> frac 4; error check
    mode = 2; exp_n_i = 6'd20; exp_frac_i = 10'd0; tol_i = 4'd2;
    kick();
    wait_valid(1200, -1, cyc);
    chk("d_latency", cyc, 1033);
    chk("d_n", n_est_o, 20);
    chk("d_frac", frac_est_o, 4);
    chk("d_err_tol2", err_o, 32'(exp_err));
    quiet(20, pulses);
    chk("d_err_sticky", err_o, 32'(exp_err));
    tol_i = 4'd4;
    kick();
    chk("d_err_clr", err_o, 0);
    wait_valid(1200, -1, cyc);
    chk("d_frac_tol4", frac_est_o, 4);
    chk("d_err_tol4", err_o, 0);

    // Reset in the middle of accumulation
    mode = 0; cval = 6'd20;
    kick();
    for (int i = 0; i < 508; i++) step();
    chk("e_busy_before", busy_o, 1);
    rstn_s = 1'b0;
    #1;
    chk("e_busy", busy_o, 0);
    chk("e_valid", valid_o, 0);
    chk("e_n", n_est_o, 0);
    chk("e_frac", frac_est_o, 0);
    chk("e_err", err_o, 0);
    step();
    rstn_s = 1'b1;
    quiet(1100, pulses);
    chk("e_no_valid", pulses, 0);
    chk("e_idle", busy_o, 0);
    kick();
    wait_valid(1200, -1, cyc);
    chk("e_restart_lat", cyc, 1033);
    chk("e_restart_n", n_est_o, 20);
    chk("e_restart_frac", frac_est_o, 0);

    // start pulsed while busy is ignored
    cval = 6'd17;
    kick();
    wait_valid(1200, 200, cyc);
    chk("f_latency", cyc, 1033);
    chk("f_n", n_est_o, 17);
    quiet(1200, pulses);
    chk("f_single_pulse", pulses, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
